// File: rtl/lfsr_prng_stream.sv
// Parametrised Fibonacci LFSR with valid/ready output, runtime seed load,
// zero-seed substitution, advance counter and full-period detection.
module lfsr_prng_stream #(
    parameter int unsigned           WIDTH = 32,
    parameter logic [WIDTH-1:0]      TAPS  = WIDTH'(32'h80200003),
    parameter logic [WIDTH-1:0]      SEED  = WIDTH'(1),
    parameter int unsigned           STEPS = 1,
    parameter int unsigned           CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             zero_seed_err,
    output logic             period_done,
    output logic [CNT_W-1:0] adv_cnt
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] state_nxt;
    logic             accept;

    assign out_data = state;
    assign accept   = out_valid & out_ready & en;

    // STEPS shifts unrolled combinationally; result lands in one cycle
    always_comb begin
        state_nxt = state;
        for (int unsigned s = 0; s < STEPS; s++) begin
            state_nxt = {state_nxt[WIDTH-2:0], ^(state_nxt & TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= SEED;
            seed_reg      <= SEED;
            out_valid     <= 1'b0;
            zero_seed_err <= 1'b0;
            period_done   <= 1'b0;
            adv_cnt       <= '0;
        end else begin
            out_valid     <= 1'b1;
            zero_seed_err <= 1'b0;
            period_done   <= 1'b0;
            if (load_valid) begin
                adv_cnt <= '0;
                if (load_data == '0) begin
                    state         <= SEED;
                    seed_reg      <= SEED;
                    zero_seed_err <= 1'b1;
                end else begin
                    state    <= load_data;
                    seed_reg <= load_data;
                end
            end else if (accept) begin
                state       <= state_nxt;
                adv_cnt     <= adv_cnt + CNT_W'(1);
                period_done <= (state_nxt == seed_reg);
            end
        end
    end

endmodule

// File: tb/tb_lfsr_prng_stream.sv
// Directed bench for lfsr_prng_stream: default, STEPS=2 and 4-bit instances.
module tb_lfsr_prng_stream;

    logic        clk;
    logic        reset_n, en, out_ready, load_valid;
    logic [31:0] load_data;
    logic        out_valid, zero_seed_err, period_done;
    logic [31:0] out_data, adv_cnt;

    logic        rst2_n, en2, rdy2, ld2;
    logic [31:0] ld_data_a;
    logic        v1, z1, p1;
    logic [31:0] d1, c1;
    logic [3:0]  ld_data_b;
    logic        v2, z2, p2;
    logic [3:0]  d2;
    logic [31:0] c2;

    int tests = 0;
    int fails = 0;

    lfsr_prng_stream u0 (
        .clk(clk), .reset_n(reset_n), .en(en), .load_valid(load_valid),
        .load_data(load_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .zero_seed_err(zero_seed_err),
        .period_done(period_done), .adv_cnt(adv_cnt)
    );

    lfsr_prng_stream #(.STEPS(2)) u1 (
        .clk(clk), .reset_n(rst2_n), .en(en2), .load_valid(ld2),
        .load_data(ld_data_a), .out_valid(v1), .out_ready(rdy2),
        .out_data(d1), .zero_seed_err(z1), .period_done(p1), .adv_cnt(c1)
    );

    lfsr_prng_stream #(.WIDTH(4), .TAPS(4'b1001), .SEED(4'd1)) u2 (
        .clk(clk), .reset_n(rst2_n), .en(en2), .load_valid(ld2),
        .load_data(ld_data_b), .out_valid(v2), .out_ready(rdy2),
        .out_data(d2), .zero_seed_err(z2), .period_done(p2), .adv_cnt(c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, en, rdy, ld;
        logic [31:0] ld_data;
        logic [31:0] e_data, e_cnt;
        logic        e_valid, e_zerr;
    } vec_t;

    vec_t vec[17];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [3:0] seq4 [15];
        int         k;

        //          rst en rdy ld  ld_data        data          cnt valid zerr
        vec[0]  = '{0, 1, 1, 0, 32'h0,        32'h1,        0, 0, 0};
        vec[1]  = '{1, 1, 1, 0, 32'h0,        32'h1,        0, 1, 0};
        vec[2]  = '{1, 1, 1, 0, 32'h0,        32'h3,        1, 1, 0};
        vec[3]  = '{1, 1, 1, 0, 32'h0,        32'h6,        2, 1, 0};
        vec[4]  = '{1, 1, 1, 0, 32'h0,        32'hD,        3, 1, 0};
        vec[5]  = '{1, 1, 1, 1, 32'h3,        32'h3,        0, 1, 0};
        vec[6]  = '{1, 1, 0, 0, 32'h0,        32'h3,        0, 1, 0};
        vec[7]  = '{1, 0, 1, 0, 32'h0,        32'h3,        0, 1, 0};
        vec[8]  = '{1, 1, 1, 0, 32'h0,        32'h6,        1, 1, 0};
        vec[9]  = '{1, 0, 0, 0, 32'h0,        32'h6,        1, 1, 0};
        vec[10] = '{1, 1, 1, 0, 32'h0,        32'hD,        2, 1, 0};
        vec[11] = '{1, 1, 1, 1, 32'h12345678, 32'h12345678, 0, 1, 0};
        vec[12] = '{1, 1, 1, 1, 32'h0,        32'h1,        0, 1, 1};
        vec[13] = '{1, 0, 0, 0, 32'h0,        32'h1,        0, 1, 0};
        vec[14] = '{1, 1, 1, 0, 32'h0,        32'h3,        1, 1, 0};
        vec[15] = '{0, 1, 1, 1, 32'h5,        32'h1,        0, 0, 0};
        vec[16] = '{1, 1, 1, 0, 32'h0,        32'h1,        0, 1, 0};

        seq4 = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

        rst2_n = 1'b0; en2 = 1'b1; rdy2 = 1'b1; ld2 = 1'b0;
        ld_data_a = '0; ld_data_b = '0;
        reset_n = 1'b0; en = 1'b1; out_ready = 1'b1; load_valid = 1'b0; load_data = '0;

        for (int i = 0; i < 17; i++) begin
            reset_n    = vec[i].rst_n;
            en         = vec[i].en;
            out_ready  = vec[i].rdy;
            load_valid = vec[i].ld;
            load_data  = vec[i].ld_data;
            @(posedge clk);
            #1;
            check($sformatf("v%0d data", i), 64'(out_data), 64'(vec[i].e_data));
            check($sformatf("v%0d cnt", i), 64'(adv_cnt), 64'(vec[i].e_cnt));
            check($sformatf("v%0d valid", i), 64'(out_valid), 64'(vec[i].e_valid));
            check($sformatf("v%0d zerr", i), 64'(zero_seed_err), 64'(vec[i].e_zerr));
            check($sformatf("v%0d pdone", i), 64'(period_done), 64'(0));
        end

        // STEPS=2 and 4-bit period sequences, running together after release
        rst2_n = 1'b1;
        @(posedge clk);
        #1;
        check("s2 valid", 64'(v1), 64'(1));
        check("s2 d0", 64'(d1), 64'h1);
        check("w4 d0", 64'(d2), 64'h1);
        check("w4 cnt0", 64'(c2), 64'(0));
        check("w4 pd0", 64'(p2), 64'(0));
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            k = i % 15;
            if (i == 1) check("s2 d1", 64'(d1), 64'h6);
            if (i == 2) check("s2 d2", 64'(d1), 64'h1B);
            check($sformatf("w4 d%0d", i), 64'(d2), 64'(seq4[k]));
            check($sformatf("w4 pd%0d", i), 64'(p2), 64'(k == 0));
            check($sformatf("w4 cnt%0d", i), 64'(c2), 64'(i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
